fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch stage upstream of the instruction memory. Holds the PC and drives the
//   memory read address. Selects the next PC from sequential, branch and JALR sources.
//   Captures the returned instruction into an IF/ID pipeline register for decode.
//   Supports stall, flush and redirect-bubble insertion.
// PARAMETERS
//   INS_ADDRESS  32        width of PC / instruction address
//   INS_W        32        instruction width
//   RESET_PC     0         PC value loaded on reset
//   NOP_INSTR    32'h13    bubble instruction (addi x0,x0,0)
// PORTS
//   clk                 in   1            clock; all state updates on rising edge
//   reset               in   1            synchronous, active-high reset
//   stall               in   1            hold PC and IF/ID contents
//   flush               in   1            replace next IF/ID contents with a bubble; PC keeps advancing
//   branch_taken        in   1            conditional-branch redirect request
//   branch_target       in   INS_ADDRESS  branch destination (PC-relative, computed by EX)
//   jalr_taken          in   1            JALR redirect request
//   jalr_target         in   INS_ADDRESS  rs1+imm from EX; bit0 cleared here
//   pc                  out  INS_ADDRESS  current PC = instruction-memory read address
//   instruction_in      in   INS_W        combinational read data from instruction memory
//   if_id_pc            out  INS_ADDRESS  PC of the instruction held in IF/ID
//   if_id_pc_plus4      out  INS_ADDRESS  if_id_pc + 4 (link value for JAL/JALR)
//   if_id_instruction   out  INS_W        instruction held in IF/ID
//   if_id_valid         out  1            IF/ID holds a real (non-bubble) instruction
//   misalign_err        out  1            sticky: a redirect target had bits[1:0] != 0
//   fetch_count         out  32           number of valid instructions delivered to IF/ID
// BEHAVIOUR
//   Reset (synchronous, active-high; dominates all other inputs):
//     pc=RESET_PC; if_id_pc=0; if_id_pc_plus4=0; if_id_instruction=NOP_INSTR;
//     if_id_valid=0; misalign_err=0; fetch_count=0; state=BOOT.
//   FSM states: BOOT, RUN.
//     BOOT: lasts one cycle. PC does not advance; IF/ID stays a bubble. Next state is RUN.
//       A redirect request arriving in BOOT is ignored.
//     RUN: per-cycle priority is redirect > stall > flush > sequential.
//   Redirect:
//     - jalr_taken wins over branch_taken.
//     - target = jalr_target & ~1 for JALR, branch_target for a branch.
//     - pc <= target. IF/ID <= bubble (NOP_INSTR, valid=0), because the current fetch is wrong-path.
//     - A redirect overrides stall.
//     - If target[1:0] != 0: misalign_err <= 1 (sticky until reset). The redirect still occurs.
//   Stall (no redirect): pc and all IF/ID outputs hold their values. fetch_count holds.
//   Flush (no redirect, no stall): pc <= pc+4. IF/ID <= bubble.
//   Sequential:
//     - pc <= pc+4.
//     - if_id_instruction <= instruction_in; if_id_pc <= pc; if_id_pc_plus4 <= pc+4; if_id_valid <= 1.
//   fetch_count increments by 1 on each edge that loads a valid instruction into IF/ID.
//   Arithmetic: pc+4 is computed modulo 2^INS_ADDRESS. At pc = 0xFFFFFFFC the next pc is 0, with no error.
//     fetch_count wraps at 2^32.
//   Latency: an instruction addressed by pc appears on if_id_* one edge later.
//     The first valid IF/ID entry appears 2 edges after reset is deasserted.
//   Reset asserted mid-stall or mid-redirect: reset values are applied on that edge; no pending
//     request survives reset.
// TESTING
//   1. Reset, then run 4 cycles with the memory model returning 0x00200093 at address 0
//      -> pc = 0, 0, 4, 8, 12 on successive edges; if_id_instruction = 0x00200093 with
//      valid=1 and if_id_pc=0; fetch_count counts valid loads.
//   2. stall held high for 3 cycles at pc=8 -> pc stays 8; if_id_* unchanged; fetch_count unchanged.
//   3. jalr_taken with jalr_target=0x11 at pc=8 -> pc=0x10 next cycle; if_id_valid=0 and
//      if_id_instruction=0x13; misalign_err stays 0.
//   4. branch_taken (target 0x40) and jalr_taken (target 0x80) in the same cycle, with stall=1
//      -> pc=0x80; bubble inserted.
//   5. branch_target=0x22 -> misalign_err=1 and pc=0x22; misalign_err stays 1 until reset.
//   6. Force pc to 0xFFFFFFFC via redirect -> next pc=0; if_id_pc_plus4=0. Then assert reset
//      while stall=1 -> all outputs return to their reset values.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, selects the next PC from the sequential, branch
// and JALR sources, and captures the fetched instruction into the IF/ID register.
// Ports: clk/reset (sync, active-high); stall, flush, branch_*, jalr_* control;
//   pc is the imem address and instruction_in is the combinational imem data;
//   if_id_* is the decode bundle; misalign_err is sticky; fetch_count counts valid loads.
module fetch_unit #(
  parameter int                     INS_ADDRESS = 32,
  parameter int                     INS_W       = 32,
  parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0,
  parameter logic [INS_W-1:0]       NOP_INSTR   = 'h13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   branch_taken,
  input  logic [INS_ADDRESS-1:0] branch_target,
  input  logic                   jalr_taken,
  input  logic [INS_ADDRESS-1:0] jalr_target,
  output logic [INS_ADDRESS-1:0] pc,
  input  logic [INS_W-1:0]       instruction_in,
  output logic [INS_ADDRESS-1:0] if_id_pc,
  output logic [INS_ADDRESS-1:0] if_id_pc_plus4,
  output logic [INS_W-1:0]       if_id_instruction,
  output logic                   if_id_valid,
  output logic                   misalign_err,
  output logic [31:0]            fetch_count
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [INS_ADDRESS-1:0] pc_d;
  logic [INS_ADDRESS-1:0] pc_inc;
  logic [INS_ADDRESS-1:0] target;
  logic                   redirect;
  logic                   id_load;
  logic                   id_bubble;
  logic                   err_set;

  assign pc_inc   = pc + INS_ADDRESS'(4);
  assign redirect = jalr_taken | branch_taken;
  // JALR clears bit 0 of rs1+imm before use.
  assign target   = jalr_taken ? {jalr_target[INS_ADDRESS-1:1], 1'b0}
                               : branch_target;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d   = RUN;
        id_bubble = 1'b1;
      end
      RUN: begin
        if (redirect) begin
          // The fetch currently in flight is wrong-path; drop it.
          pc_d      = target;
          id_bubble = 1'b1;
          err_set   = |target[1:0];
        end else if (stall) begin
          pc_d = pc;
        end else if (flush) begin
          pc_d      = pc_inc;
          id_bubble = 1'b1;
        end else begin
          pc_d    = pc_inc;
          id_load = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= BOOT;
      pc                <= RESET_PC;
      if_id_pc          <= '0;
      if_id_pc_plus4    <= '0;
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
      misalign_err      <= 1'b0;
      fetch_count       <= '0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      if (err_set)
        misalign_err <= 1'b1;
      if (id_load) begin
        if_id_pc          <= pc;
        if_id_pc_plus4    <= pc_inc;
        if_id_instruction <= instruction_in;
        if_id_valid       <= 1'b1;
        fetch_count       <= fetch_count + 32'd1;
      end else if (id_bubble) begin
        if_id_instruction <= NOP_INSTR;
        if_id_valid       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, flush,
// redirect priority, misalignment, PC wrap and reset behaviour.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jalr_taken;
  logic [31:0] jalr_target;
  logic [31:0] pc;
  logic [31:0] instruction_in;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h00200093;
    return {a[23:0], 8'h13};
  endfunction

  assign instruction_in = mem(pc);

  fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jalr_taken       (jalr_taken),
    .jalr_target      (jalr_target),
    .pc               (pc),
    .instruction_in   (instruction_in),
    .if_id_pc         (if_id_pc),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_instruction(if_id_instruction),
    .if_id_valid      (if_id_valid),
    .misalign_err     (misalign_err),
    .fetch_count      (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"}, pc, 32'h0);
    chk({tag, ".id_pc"}, if_id_pc, 32'h0);
    chk({tag, ".id_p4"}, if_id_pc_plus4, 32'h0);
    chk({tag, ".id_ins"}, if_id_instruction, 32'h13);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, 32'h0);
    chk({tag, ".err"}, {31'b0, misalign_err}, 32'h0);
    chk({tag, ".fc"}, fetch_count, 32'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jalr_taken = 1'b0; jalr_target = '0;
    tick();
    chk_reset("rst");

    // sequential fetch after reset
    reset = 1'b0;
    tick();
    chk("boot.pc", pc, 32'h0);
    chk("boot.valid", {31'b0, if_id_valid}, 32'h0);
    tick();
    chk("s1.pc", pc, 32'h4);
    chk("s1.ins", if_id_instruction, 32'h00200093);
    chk("s1.valid", {31'b0, if_id_valid}, 32'h1);
    chk("s1.id_pc", if_id_pc, 32'h0);
    chk("s1.id_p4", if_id_pc_plus4, 32'h4);
    chk("s1.fc", fetch_count, 32'd1);
    tick();
    chk("s2.pc", pc, 32'h8);
    chk("s2.id_pc", if_id_pc, 32'h4);
    chk("s2.ins", if_id_instruction, 32'h00000413);
    chk("s2.fc", fetch_count, 32'd2);

    // stall holds everything
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st.pc", pc, 32'h8);
      chk("st.id_pc", if_id_pc, 32'h4);
      chk("st.ins", if_id_instruction, 32'h00000413);
      chk("st.fc", fetch_count, 32'd2);
    end
    stall = 1'b0;

    // jalr clears bit 0
    jalr_taken = 1'b1; jalr_target = 32'h11;
    tick();
    jalr_taken = 1'b0;
    chk("jalr.pc", pc, 32'h10);
    chk("jalr.valid", {31'b0, if_id_valid}, 32'h0);
    chk("jalr.ins", if_id_instruction, 32'h13);
    chk("jalr.err", {31'b0, misalign_err}, 32'h0);
    chk("jalr.fc", fetch_count, 32'd2);
    tick();
    chk("j2.pc", pc, 32'h14);
    chk("j2.id_pc", if_id_pc, 32'h10);
    chk("j2.ins", if_id_instruction, 32'h00001013);
    chk("j2.fc", fetch_count, 32'd3);

    // jalr beats branch, redirect beats stall
    branch_taken = 1'b1; branch_target = 32'h40;
    jalr_taken = 1'b1; jalr_target = 32'h80; stall = 1'b1;
    tick();
    branch_taken = 1'b0; jalr_taken = 1'b0; stall = 1'b0;
    chk("pri.pc", pc, 32'h80);
    chk("pri.valid", {31'b0, if_id_valid}, 32'h0);
    chk("pri.ins", if_id_instruction, 32'h13);

    // flush: pc advances, bubble
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl.pc", pc, 32'h84);
    chk("fl.valid", {31'b0, if_id_valid}, 32'h0);
    chk("fl.fc", fetch_count, 32'd3);
    tick();
    chk("fl2.pc", pc, 32'h88);
    chk("fl2.id_pc", if_id_pc, 32'h84);
    chk("fl2.fc", fetch_count, 32'd4);

    // misaligned branch target, sticky error
    branch_taken = 1'b1; branch_target = 32'h22;
    tick();
    branch_taken = 1'b0;
    chk("mis.pc", pc, 32'h22);
    chk("mis.err", {31'b0, misalign_err}, 32'h1);
    tick();
    chk("mis2.pc", pc, 32'h26);
    chk("mis2.err", {31'b0, misalign_err}, 32'h1);
    chk("mis2.fc", fetch_count, 32'd5);

    // PC wrap
    branch_taken = 1'b1; branch_target = 32'hFFFFFFFC;
    tick();
    branch_taken = 1'b0;
    chk("wr.pc", pc, 32'hFFFFFFFC);
    chk("wr.err", {31'b0, misalign_err}, 32'h1);
    tick();
    chk("wr2.pc", pc, 32'h0);
    chk("wr2.id_pc", if_id_pc, 32'hFFFFFFFC);
    chk("wr2.id_p4", if_id_pc_plus4, 32'h0);
    chk("wr2.valid", {31'b0, if_id_valid}, 32'h1);
    chk("wr2.fc", fetch_count, 32'd6);

    // reset dominates stall and a pending redirect
    stall = 1'b1; reset = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    chk_reset("rst2");
    stall = 1'b0; reset = 1'b0;

    // redirect during BOOT is ignored
    tick();
    branch_taken = 1'b0;
    chk("bt.pc", pc, 32'h0);
    chk("bt.err", {31'b0, misalign_err}, 32'h0);
    tick();
    chk("bt2.pc", pc, 32'h4);
    chk("bt2.valid", {31'b0, if_id_valid}, 32'h1);
    chk("bt2.fc", fetch_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
